// File: rtl/coin_return_sequencer.sv
// rtl/coin_return_sequencer.sv - idle-timeout / user-triggered greedy coin return sequencer
module coin_return_sequencer #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31,
    parameter int WAIT_TIME  = 10,
    parameter int V0         = 100,
    parameter int V1         = 500,
    parameter int V2         = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [TOTAL_BITS-1:0] i_balance,
    input  logic                  i_activity,
    input  logic                  i_trigger_return,
    input  logic [NUM_COINS-1:0]  i_hopper_empty,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [NUM_COINS-1:0]  o_coin_sel,
    output logic                  o_deduct_valid,
    output logic [TOTAL_BITS-1:0] o_deduct_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual,
    output logic [31:0]           o_wait_time
);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_SELECT, S_DISPENSE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           wait_q, wait_d;
    logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
    logic [NUM_COINS-1:0]  sel_q, sel_d;
    logic [TOTAL_BITS-1:0] value_q, value_d;
    logic                  deduct_valid_q, deduct_valid_d;
    logic [TOTAL_BITS-1:0] deduct_value_q, deduct_value_d;
    logic [TOTAL_BITS-1:0] residual_q, residual_d;

    logic                  found;
    logic [NUM_COINS-1:0]  pick_sel;
    logic [TOTAL_BITS-1:0] pick_value;

    // Denominations beyond the three defined values read as zero and are never picked.
    function automatic logic [TOTAL_BITS-1:0] coin_value(input int k);
        case (k)
            0:       coin_value = TOTAL_BITS'(V0);
            1:       coin_value = TOTAL_BITS'(V1);
            2:       coin_value = TOTAL_BITS'(V2);
            default: coin_value = '0;
        endcase
    endfunction

    // Ascending scan so the highest affordable, stocked denomination wins.
    always_comb begin
        found      = 1'b0;
        pick_sel   = '0;
        pick_value = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_value(k) != '0 && coin_value(k) <= remaining_q && !i_hopper_empty[k]) begin
                found       = 1'b1;
                pick_sel    = '0;
                pick_sel[k] = 1'b1;
                pick_value  = coin_value(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wait_q         <= 32'(WAIT_TIME);
            remaining_q    <= '0;
            sel_q          <= '0;
            value_q        <= '0;
            deduct_valid_q <= 1'b0;
            deduct_value_q <= '0;
            residual_q     <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            remaining_q    <= remaining_d;
            sel_q          <= sel_d;
            value_q        <= value_d;
            deduct_valid_q <= deduct_valid_d;
            deduct_value_q <= deduct_value_d;
            residual_q     <= residual_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        remaining_d    = remaining_q;
        sel_d          = sel_q;
        value_d        = value_q;
        deduct_valid_d = 1'b0;
        deduct_value_d = '0;
        residual_d     = residual_q;
        case (state_q)
            S_IDLE: begin
                wait_d = 32'(WAIT_TIME);
                if (i_trigger_return && i_balance != '0) begin
                    state_d     = S_SELECT;
                    remaining_d = i_balance;
                    wait_d      = '0;
                end else if (i_balance != '0) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (i_balance == '0) begin
                    state_d = S_IDLE;
                    wait_d  = 32'(WAIT_TIME);
                end else if (i_activity) begin
                    wait_d = 32'(WAIT_TIME);
                end else if (i_trigger_return || wait_q == '0) begin
                    state_d     = S_SELECT;
                    remaining_d = i_balance;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_SELECT: begin
                if (found) begin
                    state_d = S_DISPENSE;
                    sel_d   = pick_sel;
                    value_d = pick_value;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DISPENSE: begin
                if (i_coin_ready) begin
                    state_d        = S_SELECT;
                    remaining_d    = remaining_q - value_q;
                    deduct_valid_d = 1'b1;
                    deduct_value_d = value_q;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                residual_d = remaining_q;
                wait_d     = 32'(WAIT_TIME);
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 32'(WAIT_TIME);
            end
        endcase
    end

    assign o_coin_valid   = (state_q == S_DISPENSE);
    assign o_coin_sel     = (state_q == S_DISPENSE) ? sel_q : '0;
    assign o_deduct_valid = deduct_valid_q;
    assign o_deduct_value = deduct_value_q;
    assign o_busy         = (state_q == S_SELECT) || (state_q == S_DISPENSE) || (state_q == S_DONE);
    assign o_done         = (state_q == S_DONE);
    assign o_residual     = residual_q;
    assign o_wait_time    = wait_q;

endmodule

// File: tb/tb_coin_return_sequencer.sv
// tb/tb_coin_return_sequencer.sv - directed self-checking bench for coin_return_sequencer
module tb_coin_return_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [30:0] i_balance;
    logic        i_activity;
    logic        i_trigger_return;
    logic [2:0]  i_hopper_empty;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        o_deduct_valid;
    logic [30:0] o_deduct_value;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residual;
    logic [31:0] o_wait_time;

    int tests_run    = 0;
    int tests_failed = 0;

    int coins[$];
    int coin_cyc[$];
    int deducts[$];
    int onehot_bad;
    bit done_seen;

    coin_return_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_balance(i_balance), .i_activity(i_activity),
        .i_trigger_return(i_trigger_return), .i_hopper_empty(i_hopper_empty),
        .i_coin_ready(i_coin_ready), .o_coin_valid(o_coin_valid), .o_coin_sel(o_coin_sel),
        .o_deduct_valid(o_deduct_valid), .o_deduct_value(o_deduct_value), .o_busy(o_busy),
        .o_done(o_done), .o_residual(o_residual), .o_wait_time(o_wait_time)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sel_value(input logic [2:0] sel);
        case (sel)
            3'b001:  sel_value = 100;
            3'b010:  sel_value = 500;
            3'b100:  sel_value = 1000;
            default: sel_value = -1;
        endcase
    endfunction

    // Runs the return sequence from the current cycle until o_done, recording handshakes and deducts.
    task automatic collect(input int budget);
        coins.delete(); coin_cyc.delete(); deducts.delete();
        onehot_bad = 0;
        done_seen  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (o_coin_valid && !$onehot(o_coin_sel)) onehot_bad++;
            if (!o_coin_valid && o_coin_sel != 3'b000) onehot_bad++;
            if (o_coin_valid && i_coin_ready) begin
                coins.push_back(sel_value(o_coin_sel));
                coin_cyc.push_back(c);
            end
            if (o_deduct_valid) deducts.push_back(int'(o_deduct_value));
            if (o_done) begin
                tick();
                done_seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_balance = '0; i_activity = 1'b0; i_trigger_return = 1'b0;
        i_hopper_empty = 3'b000; i_coin_ready = 1'b1;
        tick(); tick();
        tests_run++; if (o_wait_time !== 32'd10) begin tests_failed++; $display("FAIL reset_wait: got %0d expected 10", o_wait_time); end
        tests_run++; if ({o_busy, o_done, o_coin_valid, o_deduct_valid} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_coin_valid, o_deduct_valid}); end
        tests_run++; if (o_coin_sel !== 3'b000 || o_deduct_value !== 31'd0) begin tests_failed++; $display("FAIL reset_sel_value: got sel %b value %0d expected 0/0", o_coin_sel, o_deduct_value); end
        tests_run++; if (o_residual !== 31'd0) begin tests_failed++; $display("FAIL reset_residual: got %0d expected 0", o_residual); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int exp_c[3] = '{1000, 500, 100};
        i_balance = 31'd1600;
        tick();
        tests_run++; if (o_wait_time !== 32'd10 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_count_entry: got wait %0d busy %b expected 10/0", o_wait_time, o_busy); end
        repeat (10) tick();
        tests_run++; if (o_wait_time !== 32'd0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_decrements: got wait %0d busy %b expected 0/0", o_wait_time, o_busy); end
        tick();
        tests_run++; if (o_busy !== 1'b1 || o_coin_valid !== 1'b0) begin tests_failed++; $display("FAIL timeout_select: got busy %b valid %b expected 1/0", o_busy, o_coin_valid); end
        collect(40);
        tests_run++; if (coins.size() != 3 || deducts.size() != 3) begin tests_failed++; $display("FAIL timeout_counts: got coins %0d deducts %0d expected 3/3", coins.size(), deducts.size()); end
        for (int i = 0; i < 3 && i < coins.size() && i < deducts.size(); i++) begin
            tests_run++; if (coins[i] != exp_c[i] || deducts[i] != exp_c[i]) begin tests_failed++; $display("FAIL timeout_coin%0d: got coin %0d deduct %0d expected %0d", i, coins[i], deducts[i], exp_c[i]); end
        end
        tests_run++; if (coin_cyc.size() != 3 || coin_cyc[0] != 1 || coin_cyc[1] != 3 || coin_cyc[2] != 5) begin tests_failed++; $display("FAIL timeout_spacing: got %p expected '{1,3,5}", coin_cyc); end
        tests_run++; if (!done_seen || o_residual !== 31'd0 || onehot_bad != 0) begin tests_failed++; $display("FAIL timeout_done: got done %b residual %0d onehot_bad %0d expected 1/0/0", done_seen, o_residual, onehot_bad); end
        tests_run++; if (o_wait_time !== 32'd10 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle_reload: got wait %0d busy %b expected 10/0", o_wait_time, o_busy); end
        i_balance = '0;
        tick();
    endtask

    task automatic test_trigger();
        int exp_c[3] = '{500, 100, 100};
        i_balance = 31'd700;
        tick(); tick(); tick();
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        tests_run++; if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL trigger_select: got busy %b expected 1", o_busy); end
        collect(40);
        tests_run++; if (coins.size() != 3) begin tests_failed++; $display("FAIL trigger_count: got %0d expected 3", coins.size()); end
        for (int i = 0; i < 3 && i < coins.size(); i++) begin
            tests_run++; if (coins[i] != exp_c[i]) begin tests_failed++; $display("FAIL trigger_coin%0d: got %0d expected %0d", i, coins[i], exp_c[i]); end
        end
        tests_run++; if (!done_seen || o_residual !== 31'd0) begin tests_failed++; $display("FAIL trigger_done: got done %b residual %0d expected 1/0", done_seen, o_residual); end
        i_balance = '0;
        tick();
    endtask

    task automatic test_empty_hopper();
        int n500;
        int n1000;
        n500 = 0; n1000 = 0;
        i_balance = 31'd2000; i_hopper_empty = 3'b100; i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        collect(60);
        foreach (coins[i]) begin
            if (coins[i] == 500) n500++;
            if (coins[i] == 1000) n1000++;
        end
        tests_run++; if (coins.size() != 4 || n500 != 4 || n1000 != 0) begin tests_failed++; $display("FAIL empty_hopper_coins: got %0d coins (%0d x500, %0d x1000) expected 4 x500", coins.size(), n500, n1000); end
        tests_run++; if (!done_seen || o_residual !== 31'd0) begin tests_failed++; $display("FAIL empty_hopper_done: got done %b residual %0d expected 1/0", done_seen, o_residual); end
        i_balance = '0; i_hopper_empty = 3'b000;
        tick();
    endtask

    task automatic test_activity_reload();
        i_balance = 31'd300;
        tick();
        repeat (7) tick();
        tests_run++; if (o_wait_time !== 32'd3) begin tests_failed++; $display("FAIL activity_pre: got wait %0d expected 3", o_wait_time); end
        i_activity = 1'b1;
        tick();
        i_activity = 1'b0;
        tests_run++; if (o_wait_time !== 32'd10) begin tests_failed++; $display("FAIL activity_reload: got wait %0d expected 10", o_wait_time); end
        repeat (10) tick();
        tests_run++; if (o_wait_time !== 32'd0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL activity_countdown: got wait %0d busy %b expected 0/0", o_wait_time, o_busy); end
        tick();
        tests_run++; if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL activity_timeout: got busy %b expected 1", o_busy); end
        collect(40);
        tests_run++; if (coins.size() != 3 || o_residual !== 31'd0) begin tests_failed++; $display("FAIL activity_sequence: got %0d coins residual %0d expected 3/0", coins.size(), o_residual); end
        i_balance = '0;
        tick();
    endtask

    task automatic test_backpressure();
        i_balance = 31'd500; i_coin_ready = 1'b0; i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b010 || o_deduct_valid !== 1'b0) begin tests_failed++; $display("FAIL backpressure_hold%0d: got valid %b sel %b deduct %b expected 1/010/0", c, o_coin_valid, o_coin_sel, o_deduct_valid); end
            tick();
        end
        i_coin_ready = 1'b1;
        tick();
        tests_run++; if (o_deduct_valid !== 1'b1 || o_deduct_value !== 31'd500 || o_coin_valid !== 1'b0) begin tests_failed++; $display("FAIL backpressure_deduct: got dv %b value %0d valid %b expected 1/500/0", o_deduct_valid, o_deduct_value, o_coin_valid); end
        tick();
        tests_run++; if (o_done !== 1'b1 || o_deduct_valid !== 1'b0) begin tests_failed++; $display("FAIL backpressure_done: got done %b dv %b expected 1/0", o_done, o_deduct_valid); end
        i_balance = '0;
        tick(); tick();
    endtask

    task automatic test_residual();
        i_balance = 31'd50; i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        tests_run++; if (o_busy !== 1'b1 || o_coin_valid !== 1'b0) begin tests_failed++; $display("FAIL residual_select: got busy %b valid %b expected 1/0", o_busy, o_coin_valid); end
        tick();
        tests_run++; if (o_done !== 1'b1 || o_coin_valid !== 1'b0) begin tests_failed++; $display("FAIL residual_done: got done %b valid %b expected 1/0", o_done, o_coin_valid); end
        tick();
        tests_run++; if (o_residual !== 31'd50 || o_done !== 1'b0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL residual_value: got residual %0d done %b busy %b expected 50/0/0", o_residual, o_done, o_busy); end
        i_balance = '0;
        tick();
    endtask

    task automatic test_reset_mid_dispense();
        i_balance = 31'd1000; i_coin_ready = 1'b0; i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        tick();
        tests_run++; if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b100) begin tests_failed++; $display("FAIL midreset_setup: got valid %b sel %b expected 1/100", o_coin_valid, o_coin_sel); end
        reset_n = 1'b0; i_coin_ready = 1'b1;
        tick();
        tests_run++; if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_wait_time !== 32'd10 || o_deduct_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_state: got valid %b busy %b wait %0d dv %b expected 0/0/10/0", o_coin_valid, o_busy, o_wait_time, o_deduct_valid); end
        reset_n = 1'b1; i_balance = '0;
        tick();
        tests_run++; if (o_deduct_valid !== 1'b0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_deduct: got dv %b busy %b expected 0/0", o_deduct_valid, o_busy); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_trigger();
        test_empty_hopper();
        test_activity_reload();
        test_backpressure();
        test_residual();
        test_reset_mid_dispense();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/coin_return_sequencer.md
COIN_RETURN_SEQUENCER -- requirements
Module: coin_return_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_COINS, default 3, number of denominations; TOTAL_BITS, default 31, balance width; WAIT_TIME, default 10, idle-timeout cycles; V0/V1/V2, defaults 100/500/1000, coin values in ascending order.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 i_balance  input  TOTAL_BITS  current credit held by the vending datapath.
REQ-005 i_activity  input  1  coin inserted or item dispensed this cycle; restarts the timeout.
REQ-006 i_trigger_return  input  1  user return request.
REQ-007 i_hopper_empty  input  NUM_COINS  bit k high means denomination k cannot be paid out.
REQ-008 i_coin_ready  input  1  hopper accepts the presented coin this cycle.
REQ-009 o_coin_valid  output  1  coin request is presented to the hopper.
REQ-010 o_coin_sel  output  NUM_COINS  one-hot denomination being requested; zero when o_coin_valid is low.
REQ-011 o_deduct_valid / o_deduct_value  output  1 / TOTAL_BITS  one-cycle command telling the datapath to subtract the value.
REQ-012 o_busy  output  1  high in SELECT, DISPENSE and DONE.
REQ-013 o_done  output  1  one-cycle pulse when a return sequence ends.
REQ-014 o_residual  output  TOTAL_BITS  unreturnable credit from the last sequence.
REQ-015 o_wait_time  output  32  remaining timeout cycles, for display.

Function
REQ-016 States SHALL be IDLE, COUNT, SELECT, DISPENSE and DONE, held in a registered state variable.
REQ-017 IDLE: o_wait_time holds at WAIT_TIME; on i_trigger_return with i_balance != 0, go to SELECT; otherwise, if i_balance != 0, go to COUNT.
REQ-018 COUNT: in priority order:
- i_balance == 0 -> IDLE;
- i_activity -> o_wait_time reloads to WAIT_TIME;
- i_trigger_return -> SELECT;
- o_wait_time == 0 -> SELECT;
- otherwise o_wait_time decrements by 1.
REQ-019 On every entry to SELECT, the internal remaining register SHALL load i_balance and o_wait_time SHALL be set to 0.
REQ-020 SELECT (one cycle): choose the highest k with Vk <= remaining and i_hopper_empty[k] == 0; if one exists, latch it and go to DISPENSE; if none exists, go to DONE.
REQ-021 DISPENSE handshake:
- o_coin_valid = 1 and o_coin_sel = latched one-hot;
- both are held stable until the cycle in which i_coin_ready = 1;
- i_hopper_empty changes during DISPENSE are ignored.
REQ-022 On the handshake cycle: remaining -= Vk (never negative); the next cycle presents o_deduct_valid = 1 and o_deduct_value = Vk for exactly one cycle; the state returns to SELECT.
REQ-023 i_activity and i_trigger_return SHALL be ignored in SELECT, DISPENSE and DONE.
REQ-024 DONE (one cycle): o_done = 1 and o_residual <= remaining; the next state is IDLE, with o_wait_time reloaded to WAIT_TIME.
REQ-025 Greedy order SHALL yield the minimum coin count for the default values; o_coin_sel SHALL never have more than one bit set.
REQ-026 Arithmetic SHALL be unsigned at TOTAL_BITS width; the comparison Vk <= remaining guarantees no underflow.

Reset
REQ-027 With reset_n low at a clk edge, the block SHALL set:
- state = IDLE, o_wait_time = WAIT_TIME;
- remaining = 0, o_residual = 0;
- o_coin_valid = o_coin_sel = o_deduct_valid = o_deduct_value = o_busy = o_done = 0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-DISPENSE; a pending coin is abandoned and no deduct is issued.

Verification
REQ-029 Timeout: i_balance = 1600 and i_coin_ready held high, no activity -> COUNT; 10 decrements, then SELECT; coins 1000, 500, 100 are presented, each on a DISPENSE cycle after a one-cycle SELECT gap; deducts 1000, 500, 100 follow; o_done pulses with o_residual = 0.
REQ-030 Trigger: i_balance = 700 and i_trigger_return pulsed in COUNT -> coins 500, 100, 100; o_residual = 0.
REQ-031 Empty hopper: i_balance = 2000 and i_hopper_empty = 3'b100 -> four coins of 500; no 1000 is ever selected.
REQ-032 Activity reload: i_activity pulsed when o_wait_time = 3 -> o_wait_time = 10 on the next cycle, and the timeout occurs 10 cycles later.
REQ-033 Backpressure and residual:
- i_coin_ready held low for 5 cycles -> o_coin_valid and o_coin_sel stay constant and o_deduct_valid stays 0;
- i_balance = 50 -> SELECT goes directly to DONE with o_residual = 50 and no coin issued.
REQ-034 Reset mid-DISPENSE -> on the next cycle o_coin_valid = 0, state = IDLE, o_wait_time = 10, and no deduct pulse.
